// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: measures VGA sync timing and lit pixels, and reports lock or error against expected timing
// Ports: pixel_clk/rst_n (sync active-low), vga_sync_h/vga_sync_v (active-low syncs), vga_rgb (6-bit colour);
// h_total/h_sync_w/v_total/v_sync_w (last measurements), lit_pixels (last frame), frame_cnt, locked, err (pulse)
module vga_timing_monitor #(
  parameter int EXP_H_TOTAL = 800,
  parameter int EXP_H_SYNC  = 96,
  parameter int EXP_V_TOTAL = 525,
  parameter int EXP_V_SYNC  = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        vga_sync_h,
  input  logic        vga_sync_v,
  input  logic [5:0]  vga_rgb,
  output logic [9:0]  h_total,
  output logic [9:0]  h_sync_w,
  output logic [9:0]  v_total,
  output logic [9:0]  v_sync_w,
  output logic [18:0] lit_pixels,
  output logic [15:0] frame_cnt,
  output logic        locked,
  output logic        err
);
  localparam logic [9:0] L_HT  = 10'(EXP_H_TOTAL);
  localparam logic [9:0] L_HS  = 10'(EXP_H_SYNC);
  localparam logic [9:0] L_VT  = 10'(EXP_V_TOTAL);
  localparam logic [9:0] L_VS  = 10'(EXP_V_SYNC);
  localparam logic [2:0] L_LF  = 3'(LOCK_FRAMES);
  localparam logic [2:0] L_LF1 = 3'(LOCK_FRAMES - 1);
  logic        r_prev_h, r_prev_v, r_h_seen, r_v_seen, r_bad, r_to_done;
  logic [9:0]  r_h_cnt, r_h_low, r_v_line, r_v_low;
  logic [18:0] r_lit_acc;
  logic [2:0]  r_good_cnt;
  logic        w_hfall, w_hrise, w_vfall, w_vrise, w_lit, w_h_bad, w_good, w_timeout;
  assign w_hfall   = r_prev_h & ~vga_sync_h;
  assign w_hrise   = ~r_prev_h & vga_sync_h;
  assign w_vfall   = r_prev_v & ~vga_sync_v;
  assign w_vrise   = ~r_prev_v & vga_sync_v;
  assign w_lit     = vga_rgb != 6'd0;
  // a bad line capture on the frame-ending cycle still counts against that frame
  assign w_h_bad   = r_h_seen & ((w_hfall & (r_h_cnt != L_HT)) | (w_hrise & (r_h_low != L_HS)));
  assign w_good    = ~(r_bad | w_h_bad) & (r_v_line == L_VT) & (v_sync_w == L_VS);
  // fires once per stall; a fresh hfall re-arms it
  assign w_timeout = (r_h_cnt == 10'd1023) & ~r_to_done & ~w_hfall;
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_prev_h   <= 1'b1;
      r_prev_v   <= 1'b1;
      r_h_seen   <= 1'b0;
      r_v_seen   <= 1'b0;
      r_bad      <= 1'b0;
      r_to_done  <= 1'b0;
      r_h_cnt    <= 10'd0;
      r_h_low    <= 10'd0;
      r_v_line   <= 10'd0;
      r_v_low    <= 10'd0;
      r_lit_acc  <= 19'd0;
      r_good_cnt <= 3'd0;
      h_total    <= 10'd0;
      h_sync_w   <= 10'd0;
      v_total    <= 10'd0;
      v_sync_w   <= 10'd0;
      lit_pixels <= 19'd0;
      frame_cnt  <= 16'd0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_prev_h  <= vga_sync_h;
      r_prev_v  <= vga_sync_v;
      err       <= 1'b0;
      r_h_cnt   <= w_hfall ? 10'd1 : (&r_h_cnt ? r_h_cnt : r_h_cnt + 10'd1);
      r_h_low   <= w_hfall ? 10'd1 : ((!vga_sync_h && !(&r_h_low)) ? r_h_low + 10'd1 : r_h_low);
      r_v_line  <= w_vfall ? {9'd0, w_hfall} : ((w_hfall && !(&r_v_line)) ? r_v_line + 10'd1 : r_v_line);
      r_v_low   <= w_vfall ? {9'd0, w_hfall} :
                   ((!vga_sync_v && w_hfall && !(&r_v_low)) ? r_v_low + 10'd1 : r_v_low);
      r_lit_acc <= w_vfall ? {18'd0, w_lit} : ((w_lit && !(&r_lit_acc)) ? r_lit_acc + 19'd1 : r_lit_acc);
      r_bad     <= w_vfall ? 1'b0 : (r_bad | w_h_bad);
      if (w_hfall) begin
        r_h_seen  <= 1'b1;
        r_to_done <= 1'b0;
      end
      if (w_hfall && r_h_seen) h_total <= r_h_cnt;
      if (w_hrise && r_h_seen) h_sync_w <= r_h_low;
      if (w_vrise && r_v_seen) v_sync_w <= r_v_low;
      if (w_vfall) begin
        r_v_seen <= 1'b1;
        if (r_v_seen) begin
          lit_pixels <= r_lit_acc;
          v_total    <= r_v_line;
          frame_cnt  <= frame_cnt + 16'd1;
          if (w_good) begin
            r_good_cnt <= (r_good_cnt >= L_LF) ? r_good_cnt : r_good_cnt + 3'd1;
            if (r_good_cnt >= L_LF1) locked <= 1'b1;
          end else begin
            r_good_cnt <= 3'd0;
            locked     <= 1'b0;
            err        <= 1'b1;
          end
        end
      end
      // a stalled line invalidates everything measured so far
      if (w_timeout) begin
        locked     <= 1'b0;
        r_good_cnt <= 3'd0;
        r_h_seen   <= 1'b0;
        r_v_seen   <= 1'b0;
        r_to_done  <= 1'b1;
        err        <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed checks of vga_timing_monitor on a scaled-down 100x10 frame
module tb_vga_timing_monitor;
  localparam int H = 100, HS = 12, VT = 10, VS = 2;
  logic clk = 1'b0, rst_n, sync_h, sync_v;
  logic [5:0] rgb_i;
  logic [9:0] h_total, h_sync_w, v_total, v_sync_w;
  logic [18:0] lit_pixels;
  logic [15:0] frame_cnt;
  logic locked, err;
  logic lk_v, er_v;
  logic [9:0] ht_v;
  int checks = 0, passes = 0, err_cnt = 0, e0;
  vga_timing_monitor #(.EXP_H_TOTAL(H), .EXP_H_SYNC(HS), .EXP_V_TOTAL(VT), .EXP_V_SYNC(VS), .LOCK_FRAMES(2)) dut (
    .pixel_clk(clk), .rst_n(rst_n), .vga_sync_h(sync_h), .vga_sync_v(sync_v), .vga_rgb(rgb_i),
    .h_total(h_total), .h_sync_w(h_sync_w), .v_total(v_total), .v_sync_w(v_sync_w),
    .lit_pixels(lit_pixels), .frame_cnt(frame_cnt), .locked(locked), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick(input logic h, input logic v, input logic [5:0] rgb);
    sync_h = h;
    sync_v = v;
    rgb_i = rgb;
    @(posedge clk);
    #1;
    if (err === 1'b1) err_cnt++;
  endtask
  // rows r0..r1-1 of a frame: vsync low for the first vsw rows, row short_row one clock short,
  // 8x4 box of non-black pixels (colour values 1..8) at rows 4..7, columns 40..47
  task automatic frame_rows(input int vsw, input int short_row, input int r0, input int r1);
    int len;
    for (int r = r0; r < r1; r++) begin
      len = (r == short_row) ? H - 1 : H;
      for (int x = 0; x < len; x++) begin
        tick(x >= HS, r >= vsw, (r >= 4 && r < 8 && x >= 40 && x < 48) ? 6'(x - 39) : 6'd0);
        if (r == 0 && x == 0) begin
          lk_v = locked;
          er_v = err;
          ht_v = h_total;
        end
      end
    end
  endtask
  task automatic frame();
    frame_rows(VS, -1, 0, VT);
  endtask
  task automatic check_zero(input string tag);
    checks++; if ({h_total, h_sync_w, v_total, v_sync_w} !== 40'd0) $display("FAIL %s timing got %h want 0", tag, {h_total, h_sync_w, v_total, v_sync_w}); else passes++;
    checks++; if ({lit_pixels, frame_cnt} !== 35'd0) $display("FAIL %s lit/frame got %h want 0", tag, {lit_pixels, frame_cnt}); else passes++;
    checks++; if ({locked, err} !== 2'b00) $display("FAIL %s locked/err got %b want 00", tag, {locked, err}); else passes++;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    tick(1'b1, 1'b1, 6'd0);
    tick(1'b1, 1'b1, 6'd0);
    check_zero("reset");
    rst_n = 1'b1;
  endtask
  task automatic test_nominal();
    e0 = err_cnt;
    frame();
    frame();
    checks++; if (locked !== 1'b0) $display("FAIL nominal early_locked got %b want 0", locked); else passes++;
    frame();
    checks++; if (lk_v !== 1'b1) $display("FAIL nominal lock_at_vfall got %b want 1", lk_v); else passes++;
    frame();
    checks++; if (h_total !== 10'd100) $display("FAIL nominal h_total got %0d want 100", h_total); else passes++;
    checks++; if (h_sync_w !== 10'd12) $display("FAIL nominal h_sync_w got %0d want 12", h_sync_w); else passes++;
    checks++; if (v_total !== 10'd10) $display("FAIL nominal v_total got %0d want 10", v_total); else passes++;
    checks++; if (v_sync_w !== 10'd2) $display("FAIL nominal v_sync_w got %0d want 2", v_sync_w); else passes++;
    checks++; if (lit_pixels !== 19'd32) $display("FAIL nominal lit_pixels got %0d want 32", lit_pixels); else passes++;
    checks++; if (frame_cnt !== 16'd3) $display("FAIL nominal frame_cnt got %0d want 3", frame_cnt); else passes++;
    checks++; if (locked !== 1'b1) $display("FAIL nominal locked got %b want 1", locked); else passes++;
    checks++; if (err_cnt - e0 !== 0) $display("FAIL nominal err_pulses got %0d want 0", err_cnt - e0); else passes++;
  endtask
  task automatic test_short_line();
    e0 = err_cnt;
    frame_rows(VS, 5, 0, 7);
    checks++; if (lk_v !== 1'b1) $display("FAIL short entry_locked got %b want 1", lk_v); else passes++;
    checks++; if (h_total !== 10'd99) $display("FAIL short h_total got %0d want 99", h_total); else passes++;
    frame_rows(VS, 5, 7, VT);
    frame();
    checks++; if ({er_v, lk_v} !== 2'b10) $display("FAIL short err/locked got %b want 10", {er_v, lk_v}); else passes++;
    frame();
    checks++; if (lk_v !== 1'b0) $display("FAIL short relock_early got %b want 0", lk_v); else passes++;
    frame();
    checks++; if (lk_v !== 1'b1) $display("FAIL short relock got %b want 1", lk_v); else passes++;
    checks++; if (err_cnt - e0 !== 1) $display("FAIL short err_pulses got %0d want 1", err_cnt - e0); else passes++;
  endtask
  task automatic test_timeout();
    e0 = err_cnt;
    for (int i = 0; i < 1100; i++) tick(1'b1, 1'b1, 6'd0);
    checks++; if (err_cnt - e0 !== 1) $display("FAIL timeout err_pulses got %0d want 1", err_cnt - e0); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL timeout locked got %b want 0", locked); else passes++;
    checks++; if (h_total !== 10'd100) $display("FAIL timeout h_total got %0d want 100", h_total); else passes++;
    frame();
    checks++; if ({ht_v, er_v, lk_v} !== {10'd100, 2'b00}) $display("FAIL timeout first_hfall h_total/err/locked got %0d/%b/%b want 100/0/0", ht_v, er_v, lk_v); else passes++;
    frame();
    checks++; if (lk_v !== 1'b0) $display("FAIL timeout relock_early got %b want 0", lk_v); else passes++;
    frame();
    checks++; if (lk_v !== 1'b1) $display("FAIL timeout relock got %b want 1", lk_v); else passes++;
    checks++; if (err_cnt - e0 !== 1) $display("FAIL timeout total_err_pulses got %0d want 1", err_cnt - e0); else passes++;
  endtask
  task automatic test_vsync3();
    e0 = err_cnt;
    frame_rows(3, -1, 0, VT);
    checks++; if (v_sync_w !== 10'd3) $display("FAIL vsync3 v_sync_w got %0d want 3", v_sync_w); else passes++;
    frame();
    checks++; if ({er_v, lk_v} !== 2'b10) $display("FAIL vsync3 err/locked got %b want 10", {er_v, lk_v}); else passes++;
    checks++; if (v_sync_w !== 10'd2) $display("FAIL vsync3 v_sync_w_after got %0d want 2", v_sync_w); else passes++;
    frame();
    checks++; if (lk_v !== 1'b0) $display("FAIL vsync3 relock_early got %b want 0", lk_v); else passes++;
    frame();
    checks++; if (lk_v !== 1'b1) $display("FAIL vsync3 relock got %b want 1", lk_v); else passes++;
    checks++; if (err_cnt - e0 !== 1) $display("FAIL vsync3 err_pulses got %0d want 1", err_cnt - e0); else passes++;
  endtask
  task automatic test_reset_mid();
    frame_rows(VS, -1, 0, 5);
    rst_n = 1'b0;
    tick(1'b1, 1'b1, 6'd0);
    rst_n = 1'b1;
    check_zero("reset_mid");
    e0 = err_cnt;
    frame_rows(VS, -1, 5, VT);
    frame();
    frame();
    checks++; if (lk_v !== 1'b0) $display("FAIL reset_mid relock_early got %b want 0", lk_v); else passes++;
    frame();
    checks++; if (lk_v !== 1'b1) $display("FAIL reset_mid relock got %b want 1", lk_v); else passes++;
    checks++; if (frame_cnt !== 16'd2) $display("FAIL reset_mid frame_cnt got %0d want 2", frame_cnt); else passes++;
    checks++; if (err_cnt - e0 !== 0) $display("FAIL reset_mid err_pulses got %0d want 0", err_cnt - e0); else passes++;
  endtask
  initial begin
    rst_n = 1'b0;
    sync_h = 1'b1;
    sync_v = 1'b1;
    rgb_i = 6'd0;
    test_reset();
    test_nominal();
    test_short_line();
    test_timeout();
    test_vsync3();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_monitor.md
VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

Interface
REQ-001 Parameter EXP_H_TOTAL, default 800: expected clocks per line.
REQ-002 Parameter EXP_H_SYNC, default 96: expected hsync low width in clocks.
REQ-003 Parameter EXP_V_TOTAL, default 525: expected lines per frame.
REQ-004 Parameter EXP_V_SYNC, default 2: expected vsync low width in lines.
REQ-005 Parameter LOCK_FRAMES, default 2, range 1-7: consecutive good frames required for lock.
REQ-006 pixel_clk  input  1  sole clock, rising edge; one pixel per cycle.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 vga_sync_h  input  1  horizontal sync, active-low.
REQ-009 vga_sync_v  input  1  vertical sync, active-low.
REQ-010 vga_rgb  input  6  pixel colour {R[1:0],G[1:0],B[1:0]}.
REQ-011 h_total  output  10  last measured clocks per line.
REQ-012 h_sync_w  output  10  last measured hsync low width, clocks.
REQ-013 v_total  output  10  last measured lines per frame.
REQ-014 v_sync_w  output  10  last measured vsync low width, lines.
REQ-015 lit_pixels  output  19  non-black pixel count of the last complete frame.
REQ-016 frame_cnt  output  16  complete frames seen.
REQ-017 locked  output  1  timing matches expected values.
REQ-018 err  output  1  one-cycle pulse on mismatch or timeout.

Function
REQ-019 Inputs sampled directly; prev_h/prev_v registers hold the previous cycle's sync levels; hfall = prev_h & ~vga_sync_h, hrise = ~prev_h & vga_sync_h; vfall/vrise likewise.
REQ-020 h_cnt: on hfall load 1; otherwise increment, saturating at 1023.
REQ-021 On hfall with h_seen set: h_total <= h_cnt; h_seen set by the first hfall after reset (first hfall does not update h_total).
REQ-022 h_low: load 1 on hfall, increment while vga_sync_h=0 (saturate 1023); on hrise with h_seen set: h_sync_w <= h_low.
REQ-023 v_line: increments by 1 on each hfall (saturate 1023); on vfall: v_line <= hfall ? 1 : 0.
REQ-024 v_low: on vfall load hfall ? 1 : 0; while vga_sync_v=0 increment on hfall; on vrise with v_seen set: v_sync_w <= v_low.
REQ-025 lit_acc: increments every cycle vga_rgb != 0 (19-bit, saturating); on vfall load (vga_rgb != 0) and, when v_seen set, lit_pixels <= lit_acc.
REQ-026 On vfall with v_seen set: v_total <= v_line; frame_cnt <= frame_cnt + 1, wrapping 65535 -> 0; first vfall after reset only sets v_seen.
REQ-027 Sticky bad flag: set when h_total capture != EXP_H_TOTAL or h_sync_w capture != EXP_H_SYNC; cleared at every vfall.
REQ-028 Frame check at vfall with v_seen set: good iff bad=0 (including any capture on this same cycle), v_line = EXP_V_TOTAL, v_sync_w = EXP_V_SYNC.
REQ-029 good frame: good_cnt (3-bit) increments, saturating at LOCK_FRAMES; locked <= 1 in the cycle good_cnt reaches LOCK_FRAMES.
REQ-030 bad frame: good_cnt <= 0, locked <= 0, err <= 1 for one cycle.
REQ-031 Timeout: h_cnt reaching 1023 clears locked, good_cnt, h_seen, v_seen, and pulses err once (no repeat until a new hfall).
REQ-032 All outputs registered; captures visible the cycle after the detecting edge.

Reset
REQ-033 rst_n=0 at a clock edge: all outputs 0, counters 0, h_seen/v_seen/bad 0, prev_h=prev_v=1.
REQ-034 Reset mid-frame discards partial measurements; measurement resumes from the next sync edges.

Verification
REQ-035 640x480@60 stimulus (800/96/525/2, 48x48 white box otherwise black) for 4 frames -> h_total=800, h_sync_w=96, v_total=525, v_sync_w=2, lit_pixels=2304, locked=1 after 2nd checked frame, err never set, frame_cnt=3.
REQ-036 Locked, one line shortened to 799 clocks -> err pulse at that frame's end vfall, locked=0, relocks after 2 good frames.
REQ-037 hsync held high 1100 cycles -> single err pulse at h_cnt=1023, locked=0, h_total unchanged until 2nd subsequent hfall.
REQ-038 vsync pulse 3 lines -> v_sync_w=3, frame check fails, err pulse, locked=0.
REQ-039 vfall coincident with hfall -> v_line restarts at 1, v_total still 525 for nominal frames.
REQ-040 rst_n low 1 cycle mid-frame -> all outputs 0 next cycle; locked again after 3 subsequent vfalls.
